// File: rtl/button_hex_counter.sv
// Push-button conditioner: synchronisers, debounce FSM, wrapping hex counter.
// Optional auto-repeat while held: define BUTTON_HEX_COUNTER_AUTOREPEAT_EN.
module button_hex_counter #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       counterbtn_n,
    input  logic       clrbtn_n,
    output logic [3:0] count,
    output logic       press_pulse,
    output logic       wrap
);

    localparam int TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_hex_counter: parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        RELEASED,
        ARM_PRESS,
        HELD,
        ARM_RELEASE
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          btn_m, btn_s, clr_m, clr_s;
    logic          fire;
    logic [3:0]    count_nx;
    logic          pulse_nx, wrap_nx;

`ifdef BUTTON_HEX_COUNTER_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] D_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] P_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep, rep_nx;
    logic          rep_first, rep_first_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep       <= '0;
            rep_first <= 1'b1;
        end else begin
            rep       <= rep_nx;
            rep_first <= rep_first_nx;
        end
    end
`endif

    // Synchronisers reset to released so reset exit is never a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m <= 1'b1;
            btn_s <= 1'b1;
            clr_m <= 1'b1;
            clr_s <= 1'b1;
        end else begin
            btn_m <= counterbtn_n;
            btn_s <= btn_m;
            clr_m <= clrbtn_n;
            clr_s <= clr_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RELEASED;
            timer       <= '0;
            count       <= 4'h0;
            press_pulse <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            count       <= count_nx;
            press_pulse <= pulse_nx;
            wrap        <= wrap_nx;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        fire     = 1'b0;
`ifdef BUTTON_HEX_COUNTER_AUTOREPEAT_EN
        rep_nx       = rep;
        rep_first_nx = rep_first;
`endif
        unique case (state)
            RELEASED: begin
                if (!btn_s) begin
                    state_nx = ARM_PRESS;
                    timer_nx = '0;
                end
            end
            ARM_PRESS: begin
                if (btn_s) begin
                    state_nx = RELEASED;
                end else if (timer == T_LAST) begin
                    state_nx = HELD;
                    fire     = 1'b1;
`ifdef BUTTON_HEX_COUNTER_AUTOREPEAT_EN
                    rep_nx       = '0;
                    rep_first_nx = 1'b1;
`endif
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            HELD: begin
                if (btn_s) begin
                    state_nx = ARM_RELEASE;
                    timer_nx = '0;
                end
`ifdef BUTTON_HEX_COUNTER_AUTOREPEAT_EN
                else if (rep == (rep_first ? D_LAST : P_LAST)) begin
                    fire         = 1'b1;
                    rep_nx       = '0;
                    rep_first_nx = 1'b0;
                end else begin
                    rep_nx = rep + 1'b1;
                end
`endif
            end
            ARM_RELEASE: begin
                if (!btn_s) begin
                    state_nx = HELD;
`ifdef BUTTON_HEX_COUNTER_AUTOREPEAT_EN
                    rep_nx       = '0;
                    rep_first_nx = 1'b1;
`endif
                end else if (timer == T_LAST) begin
                    state_nx = RELEASED;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: state_nx = RELEASED;
        endcase
    end

    // Clear wins over a same-cycle increment; the pulse still reports the event
    always_comb begin
        pulse_nx = fire;
        wrap_nx  = fire && clr_s && (count == 4'hF);
        count_nx = count;
        if (!clr_s) begin
            count_nx = 4'h0;
        end else if (fire) begin
            count_nx = count + 4'h1;
        end
    end

endmodule

// File: tb/tb_button_hex_counter.sv
// Scoreboard bench for button_hex_counter with DEBOUNCE_CYCLES=4.
// Expected pulses (cycle, count, wrap) are queued by stimulus and checked by a monitor.
module tb_button_hex_counter;

    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
    localparam int LAT = DB + 3;

    typedef struct {
        int         cyc;
        logic [3:0] count;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       counterbtn_n = 1'b1;
    logic       clrbtn_n = 1'b1;
    logic [3:0] count;
    logic       press_pulse;
    logic       wrap;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       q[$];
    logic [3:0] mcount = 4'h0;
    logic       clr_held = 1'b0;

    button_hex_counter #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .counterbtn_n(counterbtn_n),
        .clrbtn_n    (clrbtn_n),
        .count       (count),
        .press_pulse (press_pulse),
        .wrap        (wrap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic add_event(input int t);
        exp_t e;
        e.cyc   = t;
        e.wrap  = (mcount == 4'hF) && !clr_held;
        mcount  = clr_held ? 4'h0 : mcount + 4'h1;
        e.count = mcount;
        q.push_back(e);
    endtask

    // Button driven low at cycle c0 and held for hold cycles
    task automatic schedule(input int c0, input int hold);
        add_event(c0 + LAT);
`ifdef BUTTON_HEX_COUNTER_AUTOREPEAT_EN
        for (int t = c0 + LAT + RD; t <= c0 + hold + 2; t += RP) add_event(t);
`endif
    endtask

    task automatic press(input int hold, input int rel);
        @(negedge clk);
        schedule(cyc, hold);
        counterbtn_n = 1'b0;
        repeat (hold) @(negedge clk);
        counterbtn_n = 1'b1;
        repeat (rel) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && press_pulse === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d count %0h", cyc, count);
            end else begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse_cycle got %0d want %0d", cyc, e.cyc);
                end
                chk("pulse_count", {2'b0, count}, {2'b0, e.count});
                chk("pulse_wrap", {5'b0, wrap}, {5'b0, e.wrap});
            end
        end
        if (wrap === 1'b1 && press_pulse !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wrap_without_pulse at cycle %0d", cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c1;
        // Test 1: reset state and quiet idle
        #1;
        chk("reset_out", {count, press_pulse, wrap}, 6'h0);
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", {count, press_pulse, wrap}, 6'h0);
        end
        rst_n = 1'b1;
        repeat (50) begin
            @(negedge clk);
            chk("idle_out", {count, press_pulse, wrap}, 6'h0);
        end

        // Test 2: clean press
        press(20, 20);
        chk("t2_count", {2'b0, count}, {2'b0, mcount});

        // Test 3: bounce gives nothing, release bounce gives one event
        @(negedge clk);
        counterbtn_n = 1'b0;
        repeat (3) @(negedge clk);
        counterbtn_n = 1'b1;
        @(negedge clk);
        counterbtn_n = 1'b0;
        repeat (3) @(negedge clk);
        counterbtn_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("bounce_no_event", {2'b0, count}, {2'b0, mcount});
        @(negedge clk);
        schedule(cyc, 10);
        counterbtn_n = 1'b0;
        repeat (10) @(negedge clk);
        counterbtn_n = 1'b1;
        repeat (2) @(negedge clk);
        counterbtn_n = 1'b0;
        @(negedge clk);
        counterbtn_n = 1'b1;
        repeat (14) @(negedge clk);
        chk("release_bounce", {2'b0, count}, {2'b0, mcount});

        // Test 4: 16 presses from zero wrap back to zero
        rst_n = 1'b0;
        mcount = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t4_start", {2'b0, count}, 6'h0);
        repeat (16) press(8, 10);
        chk("t4_wrapped", {2'b0, count}, 6'h0);

        // Test 5: clear latency and clear priority
        repeat (5) press(8, 10);
        chk("t5_five", {2'b0, count}, 6'h5);
        clrbtn_n = 1'b0;
        clr_held = 1'b1;
        mcount = 4'h0;
        repeat (2) @(negedge clk);
        chk("clr_not_yet", {2'b0, count}, 6'h5);
        @(negedge clk);
        chk("clr_latency", {2'b0, count}, 6'h0);
        press(10, 10);
        chk("clr_priority", {2'b0, count}, 6'h0);
        clrbtn_n = 1'b1;
        clr_held = 1'b0;
        repeat (3) @(negedge clk);
        chk("clr_release", {2'b0, count}, 6'h0);

        // Test 6: reset mid ARM_PRESS discards the partial press
        press(8, 10);
        chk("t6_one", {2'b0, count}, 6'h1);
        @(negedge clk);
        counterbtn_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        mcount = 4'h0;
        #1;
        chk("async_reset", {count, press_pulse, wrap}, 6'h0);
        repeat (2) @(negedge clk);
        c1 = cyc;
        schedule(c1, 10);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        counterbtn_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("t6_after", {2'b0, count}, {2'b0, mcount});

        // Long hold: one event, or repeats when auto-repeat is built in
        press(31, 12);
        chk("long_hold", {2'b0, count}, {2'b0, mcount});

        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses got %0d left want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
